// File: rtl/alu_rr_arbiter.sv
// -----------------------------------------------------------------------------
// alu_rr_arbiter
//
// Shares one WIDTH-bit ALU between two requester ports. Requests are granted
// round-robin, executed one at a time, and returned on a single response
// channel tagged with the requester id. A completed-operation counter tracks
// every response that has been consumed.
//
// Handshake semantics (all channels): a transfer happens on a rising clock edge
// where valid && ready are both high. A producer may raise or drop valid at
// will before the transfer; once rsp_valid is raised, rsp_id/rsp_result/
// rsp_zero stay stable until the transfer completes.
//
// Ports
//   clk                 system clock, rising edge
//   rst                 asynchronous reset, active low
//   m0_valid/m0_ready   port 0 request handshake
//   m0_op, m0_a, m0_b   port 0 opcode and operands
//   m1_valid/m1_ready   port 1 request handshake
//   m1_op, m1_a, m1_b   port 1 opcode and operands
//   rsp_valid/rsp_ready response handshake
//   rsp_id              requester of the response (0/1)
//   rsp_result          ALU result
//   rsp_zero            rsp_result == 0
//   busy                FSM not in IDLE
//   op_count            completed responses, wraps modulo 2^CNTW
//   state_dbg           current FSM state (0 IDLE, 1 EXEC, 2 RESP)
// -----------------------------------------------------------------------------
module alu_rr_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_valid,
  output logic             m0_ready,
  input  logic [2:0]       m0_op,
  input  logic [WIDTH-1:0] m0_a,
  input  logic [WIDTH-1:0] m0_b,
  input  logic             m1_valid,
  output logic             m1_ready,
  input  logic [2:0]       m1_op,
  input  logic [WIDTH-1:0] m1_a,
  input  logic [WIDTH-1:0] m1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             busy,
  output logic [CNTW-1:0]  op_count,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q;
  logic             prio_q;       // port that wins when both are valid
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             id_q;         // requester of the operation in flight
  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic             rsp_zero_q;
  logic [CNTW-1:0]  op_count_q;

  logic             grant_id;
  logic [WIDTH-1:0] result_d;

  // Arbitration: a lone valid port wins outright; a tie goes to prio_q.
  always_comb begin
    grant_id = 1'b0;
    if (m0_valid && m1_valid) begin
      grant_id = prio_q;
    end else if (m1_valid) begin
      grant_id = 1'b1;
    end
  end

  // Readies are qualified with the port's own valid so at most one is high.
  assign m0_ready = (state_q == IDLE) && m0_valid && (grant_id == 1'b0);
  assign m1_ready = (state_q == IDLE) && m1_valid && (grant_id == 1'b1);

  // ALU on the captured operands.
  always_comb begin
    result_d = '0;
    unique case (op_q)
      3'b000:  result_d = a_q + b_q;
      3'b001:  result_d = a_q - b_q;
      3'b010:  result_d = a_q & b_q;
      3'b011:  result_d = a_q | b_q;
      3'b100:  result_d = ~a_q;
      3'b101:  result_d = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      op_count_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (m0_ready || m1_ready) begin
            op_q    <= grant_id ? m1_op : m0_op;
            a_q     <= grant_id ? m1_a  : m0_a;
            b_q     <= grant_id ? m1_b  : m0_b;
            id_q    <= grant_id;
            prio_q  <= ~grant_id;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_q <= result_d;
          rsp_zero_q   <= (result_d == '0);
          rsp_id_q     <= id_q;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            op_count_q <= op_count_q + 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign busy       = (state_q != IDLE);
  assign op_count   = op_count_q;
  assign state_dbg  = state_q;

endmodule
